// File: rtl/branch_predictor_btb_pkg.sv
// Shared types for the fetch-stage BTB predictor: counter encoding, PC width,
// table entry and feedback tracking element.
package branch_predictor_btb_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        CTR_SN = 2'b00,
        CTR_WN = 2'b01,
        CTR_WT = 2'b10,
        CTR_ST = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e CTR_ALLOC = CTR_WT;

    // Tag is held right-aligned at full PC width; the unused top bits stay zero.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        bp_ctr_e         ctr;
    } bp_entry_t;

    typedef struct packed {
        logic            br;
        logic [PC_W-1:0] pc;
    } bp_track_t;

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch/decode/execute signal bundle between the pipeline and the BTB predictor.
interface branch_predictor_btb_if
    import branch_predictor_btb_pkg::*;
();
    logic [PC_W-1:0] f_pc;
    logic [PC_W-1:0] d_pc;
    logic            d_is_branch;
    logic [PC_W-1:0] target_addr;
    logic            x_predict_res;
    logic [PC_W-1:0] f_predict_addr;
    logic            f_predict_valid;

    modport master (
        output f_pc, d_pc, d_is_branch, target_addr, x_predict_res,
        input  f_predict_addr, f_predict_valid
    );

    modport slave (
        input  f_pc, d_pc, d_is_branch, target_addr, x_predict_res,
        output f_predict_addr, f_predict_valid
    );
endinterface

// File: rtl/bp_sat_counter2.sv
// Combinational next-state of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter2
    import branch_predictor_btb_pkg::*;
(
    input  bp_ctr_e ctr_i,
    input  logic    taken_i,
    output bp_ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            CTR_SN: ctr_o = taken_i ? CTR_WN : CTR_SN;
            CTR_WN: ctr_o = taken_i ? CTR_WT : CTR_SN;
            CTR_WT: ctr_o = taken_i ? CTR_ST : CTR_WN;
            CTR_ST: ctr_o = taken_i ? CTR_ST : CTR_WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry 2-bit counters; combinational lookup on f_pc,
// target learning from decode, counter training from delayed execute feedback.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int IDX_BITS = 3,
    parameter int X_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_predictor_btb_if.slave bp
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_SH  = IDX_BITS + 2;

    bp_entry_t tbl_q [ENTRIES];
    bp_entry_t tbl_d [ENTRIES];
    bp_track_t trk_q [X_LAT];

    logic [IDX_BITS-1:0] f_idx, d_idx, x_idx;
    logic [PC_W-1:0]     f_tag, d_tag, x_tag;
    bp_track_t           x_elem;
    logic                f_hit, f_taken, x_match, d_hit;
    bp_ctr_e             x_ctr_nxt;
    logic                unused_pc_bits;

    assign x_elem = trk_q[X_LAT-1];

    assign f_idx = bp.f_pc[IDX_BITS+1:2];
    assign d_idx = bp.d_pc[IDX_BITS+1:2];
    assign x_idx = x_elem.pc[IDX_BITS+1:2];
    assign f_tag = bp.f_pc >> TAG_SH;
    assign d_tag = bp.d_pc >> TAG_SH;
    assign x_tag = x_elem.pc >> TAG_SH;

    assign unused_pc_bits = ^{bp.d_pc[1:0], x_elem.pc[1:0]};

    assign f_hit   = tbl_q[f_idx].valid && (tbl_q[f_idx].tag == f_tag);
    assign f_taken = f_hit && (tbl_q[f_idx].ctr inside {CTR_WT, CTR_ST});
    assign x_match = x_elem.br && tbl_q[x_idx].valid && (tbl_q[x_idx].tag == x_tag);
    assign d_hit   = tbl_q[d_idx].valid && (tbl_q[d_idx].tag == d_tag);

    assign bp.f_predict_valid = f_taken;
    assign bp.f_predict_addr  = f_taken ? tbl_q[f_idx].target : bp.f_pc + 32'd4;

    bp_sat_counter2 u_ctr (
        .ctr_i   (tbl_q[x_idx].ctr),
        .taken_i (bp.x_predict_res),
        .ctr_o   (x_ctr_nxt)
    );

    // Feedback lands first so a same-index decode hit keeps the trained counter,
    // while a decode miss overwrites the whole entry.
    always_comb begin
        tbl_d = tbl_q;
        if (x_match) begin
            tbl_d[x_idx].ctr = x_ctr_nxt;
        end
        if (bp.d_is_branch) begin
            if (d_hit) begin
                tbl_d[d_idx].target = bp.target_addr;
            end else begin
                tbl_d[d_idx].valid  = 1'b1;
                tbl_d[d_idx].tag    = d_tag;
                tbl_d[d_idx].target = bp.target_addr;
                tbl_d[d_idx].ctr    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid <= 1'b0;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // trk_q[0] is the newest decode; trk_q[X_LAT-1] is the branch now in execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < X_LAT; i++) begin
                trk_q[i].br <= 1'b0;
            end
        end else begin
            trk_q[0] <= '{br: bp.d_is_branch, pc: bp.d_pc};
            for (int i = 1; i < X_LAT; i++) begin
                trk_q[i] <= trk_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: directed training scenarios then
// randomized traffic, checked against a cycle-indexed behavioural model.
module tb_branch_predictor_btb;

    localparam int IDX_BITS = 3;
    localparam int X_LAT    = 2;
    localparam int ENTRIES  = 1 << IDX_BITS;

    typedef struct {
        logic [31:0] fpc;
        logic [31:0] a;
        logic        v;
        bit          spot;
        logic [31:0] sa;
        logic        sv;
        string       nm;
    } sb_item_t;

    logic clk;
    logic rst_n;
    branch_predictor_btb_if bp_if ();

    branch_predictor_btb #(.IDX_BITS(IDX_BITS), .X_LAT(X_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    sb_item_t sb_q[$];

    // Behavioural model: plain arrays plus a per-cycle decode history.
    bit          m_vld [ENTRIES];
    logic [31:0] m_tag [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    int          m_ctr [ENTRIES];
    bit          hist_br [int];
    logic [31:0] hist_pc [int];
    int          ncyc = 0;
    int          first_cyc = 0;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc >> (IDX_BITS + 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
        first_cyc = ncyc + 1;
    endtask

    task automatic m_lookup(input logic [31:0] fpc, output logic [31:0] a, output logic v);
        int i;
        i = m_idx(fpc);
        v = m_vld[i] && (m_tag[i] == m_tagof(fpc)) && (m_ctr[i] >= 2);
        a = v ? m_tgt[i] : fpc + 32'd4;
    endtask

    task automatic m_step(input logic dbr, input logic [31:0] dpc, input logic [31:0] tgt, input logic xr);
        int e, i;
        e = ncyc - X_LAT;
        if (e >= first_cyc && hist_br.exists(e) && hist_br[e]) begin
            i = m_idx(hist_pc[e]);
            if (m_vld[i] && m_tag[i] == m_tagof(hist_pc[e])) begin
                if (xr) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end
        if (dbr) begin
            i = m_idx(dpc);
            if (m_vld[i] && m_tag[i] == m_tagof(dpc)) begin
                m_tgt[i] = tgt;
            end else begin
                m_vld[i] = 1'b1;
                m_tag[i] = m_tagof(dpc);
                m_tgt[i] = tgt;
                m_ctr[i] = 2;
            end
        end
        hist_br[ncyc] = dbr;
        hist_pc[ncyc] = dpc;
    endtask

    task automatic drive(input logic rst, input logic [31:0] fpc, input logic dbr,
                         input logic [31:0] dpc, input logic [31:0] tgt, input logic xr,
                         input bit spot, input logic [31:0] sa, input logic sv, input string nm);
        sb_item_t it;
        @(negedge clk);
        rst_n                = rst;
        bp_if.f_pc           = fpc;
        bp_if.d_is_branch    = dbr;
        bp_if.d_pc           = dpc;
        bp_if.target_addr    = tgt;
        bp_if.x_predict_res  = xr;
        if (!rst) m_reset();
        it.fpc  = fpc;
        m_lookup(fpc, it.a, it.v);
        it.spot = spot;
        it.sa   = sa;
        it.sv   = sv;
        it.nm   = nm;
        sb_q.push_back(it);
        if (rst) m_step(dbr, dpc, tgt, xr);
        ncyc++;
    endtask

    task automatic c(input logic [31:0] fpc, input logic dbr, input logic [31:0] dpc,
                     input logic [31:0] tgt, input logic xr);
        drive(1'b1, fpc, dbr, dpc, tgt, xr, 1'b0, 32'd0, 1'b0, "");
    endtask

    task automatic k(input logic [31:0] fpc, input logic dbr, input logic [31:0] dpc,
                     input logic [31:0] tgt, input logic xr,
                     input logic [31:0] sa, input logic sv, input string nm);
        drive(1'b1, fpc, dbr, dpc, tgt, xr, 1'b1, sa, sv, nm);
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents one result.
    initial begin
        sb_item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                checks++;
                if (bp_if.f_predict_addr !== it.a || bp_if.f_predict_valid !== it.v) begin
                    errors++;
                    $display("FAIL model_cmp f_pc=%h got addr=%h valid=%b exp addr=%h valid=%b",
                             it.fpc, bp_if.f_predict_addr, bp_if.f_predict_valid, it.a, it.v);
                end
                if (it.spot) begin
                    checks++;
                    if (bp_if.f_predict_addr !== it.sa || bp_if.f_predict_valid !== it.sv) begin
                        errors++;
                        $display("FAIL %s f_pc=%h got addr=%h valid=%b exp addr=%h valid=%b",
                                 it.nm, it.fpc, bp_if.f_predict_addr, bp_if.f_predict_valid,
                                 it.sa, it.sv);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fpc, dpc, tgt;
        rst_n               = 1'b0;
        bp_if.f_pc          = '0;
        bp_if.d_pc          = '0;
        bp_if.d_is_branch   = 1'b0;
        bp_if.target_addr   = '0;
        bp_if.x_predict_res = 1'b0;

        drive(1'b0, 32'h0FF0, 0, 0, 0, 0, 1'b1, 32'h0FF4, 1'b0, "reset");
        drive(1'b0, 32'h0FF0, 0, 0, 0, 0, 1'b1, 32'h0FF4, 1'b0, "reset");
        k(32'h0FF0, 0, 0, 0, 0, 32'h0FF4, 0, "release");

        // Allocate, then not-taken training down to 00 and saturation there.
        k(32'h1008, 1, 32'h1008, 32'h1010, 0, 32'h100C, 0, "pre_alloc");
        k(32'h1008, 0, 0, 0, 0, 32'h1010, 1, "alloc");
        k(32'h1008, 0, 0, 0, 0, 32'h1010, 1, "nt1_pending");
        k(32'h1008, 1, 32'h1008, 32'h1010, 1, 32'h100C, 0, "nt1");
        k(32'h1008, 0, 0, 0, 1, 32'h100C, 0, "ignored_x");
        c(32'h1008, 1, 32'h1008, 32'h1010, 0);
        c(32'h0000, 0, 0, 0, 1);
        c(32'h1008, 0, 0, 0, 0);
        c(32'h1008, 1, 32'h1008, 32'h1010, 0);
        c(32'h0000, 0, 0, 0, 0);
        c(32'h1008, 0, 0, 0, 1);
        k(32'h1008, 0, 0, 0, 0, 32'h100C, 0, "nt_sat");

        // Taken training on a two-branch loop, saturating at 11.
        c(32'h1000, 1, 32'h100C, 32'h1014, 0);
        c(32'h1004, 1, 32'h1014, 32'h1000, 0);
        c(32'h1008, 0, 0, 0, 1);
        c(32'h100C, 0, 0, 0, 1);
        c(32'h1010, 1, 32'h1014, 32'h1000, 0);
        c(32'h1014, 0, 0, 0, 0);
        c(32'h1000, 0, 0, 0, 1);
        c(32'h1004, 1, 32'h1014, 32'h1000, 0);
        k(32'h100C, 0, 0, 0, 0, 32'h1014, 1, "loop_100c");
        c(32'h1010, 0, 0, 0, 0);
        k(32'h1014, 0, 0, 0, 0, 32'h1000, 1, "loop_1014_sat");

        // Alias replacement, stale feedback dropped, new entry starts at 10.
        c(32'h1018, 1, 32'h1014, 32'h1000, 0);
        c(32'h101C, 1, 32'h1034, 32'h2000, 0);
        k(32'h1014, 0, 0, 0, 1, 32'h1018, 0, "alias_miss");
        k(32'h1034, 0, 0, 0, 0, 32'h2000, 1, "alias_new");
        k(32'h1034, 0, 0, 0, 0, 32'h1038, 0, "stale_dropped");
        k(32'hFFFFFFFC, 0, 0, 0, 0, 32'h0000_0000, 0, "wrap");
        k(32'h100E, 0, 0, 0, 0, 32'h1014, 1, "low_bits");

        for (int n = 0; n < 600; n++) begin
            fpc = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) fpc = fpc + 32'($urandom_range(1, 3) << 5);
            if ($urandom_range(0, 49) == 0) fpc = 32'hFFFFFFFC;
            dpc = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) dpc = dpc + 32'($urandom_range(1, 3) << 5);
            tgt = $urandom;
            drive(($urandom_range(0, 79) != 0), fpc, 1'($urandom_range(0, 1)), dpc, tgt,
                  1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0, "");
        end

        @(negedge clk);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending items exp 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
